// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding seen on the control-unit op bus and the sequencer states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling for muldiv_unit: magnitude extraction of the operands on the
// load path and conditional two's-complement negation of the raw result.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 a_neg,
  output logic                 b_neg,
  output logic [WIDTH-1:0]     a_mag,
  output logic [WIDTH-1:0]     b_mag,
  input  logic                 mult_op,
  input  logic                 neg_prod,
  input  logic                 neg_quot,
  input  logic                 neg_rem,
  input  logic [2*WIDTH-1:0]   fix_in,
  output logic [2*WIDTH-1:0]   fix_out
);

  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    a_neg = signed_op & a[WIDTH-1];
    b_neg = signed_op & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // A product is negated as one 2*WIDTH value; a divide result negates
  // quotient and remainder independently.
  always_comb begin
    fix_hi  = fix_in[2*WIDTH-1:WIDTH];
    fix_lo  = fix_in[WIDTH-1:0];
    fix_out = fix_in;
    if (mult_op) begin
      if (neg_prod) fix_out = -fix_in;
    end else begin
      fix_out = {(neg_rem ? -fix_hi : fix_hi), (neg_quot ? -fix_lo : fix_lo)};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide with a start/done handshake,
// producing HI/LO results; one result bit per cycle over WIDTH cycles.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [1:0]         op_q;
  logic               neg_a_q, neg_b_q, dz_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   opb;

  logic               in_div, in_signed, zero_div, q_mult;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;

  assign in_div    = op[1];
  assign in_signed = ~op[0];
  assign zero_div  = in_div && (b == '0);
  assign q_mult    = ~op_q[1];
  assign fix_in    = q_mult ? acc : {rem[WIDTH-1:0], acc[WIDTH-1:0]};

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_op (in_signed),
    .a         (a),
    .b         (b),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .mult_op   (q_mult),
    .neg_prod  (neg_a_q ^ neg_b_q),
    .neg_quot  (neg_a_q ^ neg_b_q),
    .neg_rem   (neg_a_q),
    .fix_in    (fix_in),
    .fix_out   (fix_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = zero_div ? DONE : RUN;
      RUN:  if (cnt == LAST) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Multiply shifts the product right through acc, adding the multiplicand
  // into the upper half; divide shifts the dividend out of acc[WIDTH-1:0]
  // into rem while quotient bits fill acc from the LSB.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_trial = {rem, acc[WIDTH-1]} - {2'b00, opb};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= OP_MULT;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
    end else begin
      done <= (state == DONE);
      busy <= (next_state != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            neg_a_q  <= a_neg;
            neg_b_q  <= b_neg;
            dz_q     <= zero_div;
            div_zero <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            opb      <= in_div ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (q_mult) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else if (!div_trial[WIDTH+1]) begin
            rem <= div_trial[WIDTH:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift;
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          hi <= fix_out[2*WIDTH-1:WIDTH];
          lo <= fix_out[WIDTH-1:0];
        end
        DONE: begin
          if (dz_q) div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences and randomized ops against an integer-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  op, op8;
  logic [31:0] a, b, hi, lo;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy, done, div_zero;
  logic        busy8, done8, div_zero8;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  vec_t        tbl[12];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  // Reference: {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ph,
                                        input logic [31:0] pl);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    p  = '0;
    if (o[1] && y == 32'd0) return {1'b1, ph, pl};
    case (o)
      OP_MULT:  p = 64'(sx * sy);
      OP_MULTU: p = ux * uy;
      OP_DIV: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      default: p = {32'(ux % uy), 32'(ux / uy)};
    endcase
    return {1'b0, p};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input int glitch, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check_output("busy_after_start", busy, 1);
      start = (lat == glitch);
      if (lat == glitch) begin op = OP_DIVU; a = $urandom; b = '0; end
    end
  endtask

  task automatic run_and_check(input string name, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                               input logic edz, input int elat, input int glitch);
    int lat;
    apply_stimulus(o, x, y, glitch, lat);
    check_output({name, "_latency"}, lat, elat);
    check_output({name, "_hi"}, hi, eh);
    check_output({name, "_lo"}, lo, el);
    check_output({name, "_div_zero"}, div_zero, edz);
    check_output({name, "_busy_at_done"}, busy, 1);
    @(posedge clk); #1;
    check_output({name, "_done_pulse"}, done, 0);
    check_output({name, "_busy_clear"}, busy, 0);
  endtask

  task automatic run8(input string name, input logic [1:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el);
    int lat;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({name, "_latency"}, lat, 10);
    check_output({name, "_hi"}, hi8, eh);
    check_output({name, "_lo"}, lo8, el);
    check_output({name, "_div_zero"}, div_zero8, 0);
  endtask

  initial begin
    int          lat, seen;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    logic [64:0] r;

    tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    tbl[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    tbl[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    tbl[4]  = '{OP_DIVU,  32'd68,       32'd7,        32'd5,        32'd9,        1'b0, 34};
    tbl[5]  = '{OP_DIVU,  32'd123,      32'd0,        32'd5,        32'd9,        1'b1, 1};
    tbl[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
    tbl[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0, 34};
    tbl[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    tbl[9]  = '{OP_MULT,  32'd0,        32'd12345,    32'd0,        32'd0,        1'b0, 34};
    tbl[10] = '{OP_DIV,   32'd55,       32'd0,        32'd0,        32'd0,        1'b1, 1};
    tbl[11] = '{OP_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 34};

    start = 0; op = 0; a = 0; b = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hi", hi, 0);
    check_output("reset_lo", lo, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_div_zero", div_zero, 0);
    check_output("reset8_lo", lo8, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat, -1);
      prev_hi = tbl[i].hi;
      prev_lo = tbl[i].lo;
    end

    // A start arriving mid-run must not disturb the operation in flight.
    run_and_check("glitch_start", OP_MULTU, 32'd1000, 32'd3, 32'd0, 32'd3000, 1'b0, 34, 10);
    prev_hi = 32'd0;
    prev_lo = 32'd3000;

    // Start held high through DONE chains a second operation.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("b2b_first_latency", lat, 34);
    check_output("b2b_first_lo", lo, 63);
    op = OP_DIVU; a = 32'd20; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("b2b_busy_kept", busy, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("b2b_second_latency", lat, 34);
    check_output("b2b_second_hi", hi, 2);
    check_output("b2b_second_lo", lo, 6);
    prev_hi = 32'd2;
    prev_lo = 32'd6;
    @(posedge clk); #1;

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("midreset_hi", hi, 0);
    check_output("midreset_lo", lo, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check_output("midreset_no_done", seen, 0);
    run_and_check("after_reset", OP_MULT, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 34, -1);
    prev_hi = 32'hFFFFFFFF;
    prev_lo = 32'hFFFFFFF4;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = 32'($urandom_range(1, 20));
        2: rx = 32'h80000000;
        3: ry = 32'hFFFFFFFF;
        default: ;
      endcase
      r = model(ro, rx, ry, prev_hi, prev_lo);
      run_and_check($sformatf("rand%0d", i), ro, rx, ry, r[63:32], r[31:0], r[64],
                    r[64] ? 1 : 34, -1);
      prev_hi = r[63:32];
      prev_lo = r[31:0];
    end

    run8("w8_div_min", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
    run8("w8_mult_neg", OP_MULT, 8'hFD, 8'h07, 8'hFF, 8'hEB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
